reg_wb_sched: RTL and testbench
===============================

Name: reg_wb_sched

Overview:
Writeback scheduler and scoreboard in front of the 32x64 register file's single write port. It arbitrates round-robin between NUM_SRC result producers (ALU, load unit, ...) and drives write_en/write_reg/write_data from registers. It tracks one busy bit per architectural register so issue logic stalls RAW/WAW hazards. It also suppresses x0 writes, because the register file does not guard x0.

Parameters:
NUM_SRC, 2, number of writeback requesters (>=2)
XLEN, 64, data width
RA_W, 5, register address width (32 registers)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
src_valid  input  NUM_SRC  requester i has a result
src_reg  input  NUM_SRC*RA_W  destination reg of requester i, slice i = [i*RA_W +: RA_W]
src_data  input  NUM_SRC*XLEN  result of requester i, slice i
src_ready  output  NUM_SRC  one-hot grant; result accepted when valid&ready
issue_en  input  1  issue stage requests to reserve issue_reg
issue_reg  input  RA_W  destination of instruction being issued
issue_ready  output  1  reservation allowed this cycle
write_en  output  1  to register file write_en
write_reg  output  RA_W  to register file write_reg
write_data  output  XLEN  to register file write_data
busy  output  32  scoreboard, bit r = write to r outstanding

Behaviour:
- Reset (rst=1 at edge): write_en=0, write_reg=0, write_data=0, busy=0, rr_ptr=0. Reset dominates every other event that cycle. Accepted-but-unwritten data is discarded.
- Arbitration (combinational): search from rr_ptr upward modulo NUM_SRC. The first i with src_valid[i] gets src_ready[i]=1, and all others are 0.
- src_ready is all-zero when no src_valid is set, and also during rst.
- rr_ptr update: after an accept by source g, rr_ptr <= (g+1) mod NUM_SRC. It is unchanged when there is no accept.
- Exactly one accept per cycle; throughput is 1 write/cycle. Non-granted requesters hold valid/reg/data stable until granted.
- Write latency: accept at edge N gives write_en=1, write_reg=src_reg[g], write_data=src_data[g] during cycle N+1.
- With no accept, write_en=0 next cycle. write_reg/write_data hold their last value.
- x0: an accept with src_reg=0 is consumed normally (ready, rr_ptr advances) but gives write_en=0.
- issue_ready = (issue_reg==0) | ~busy[issue_reg]. It uses the registered busy only; a same-cycle clear does not unblock it.
- Reservation: issue_en & issue_ready & issue_reg!=0 sets busy[issue_reg] at the edge. issue_en with issue_ready=0 is ignored, and the issuer retries.
- Clear: a write accept of reg r!=0 clears busy[r] at the same edge that loads write_* (busy falls as write_en rises).
- Set and clear of the same register at the same edge: set wins and busy stays 1. This is only reachable when the reservation is legal.
- An accept for a register that is not busy is legal: data is written and busy stays 0.
- busy[0] is constant 0.
- At most one outstanding write per register, because WAW is stalled by issue_ready.

Decomposition:
- Shared package regfile_pkg: constants NUM_REGS=32, XLEN=64, RA_W=5, REG_ZERO=5'd0, and typedef reg_addr_t = logic [RA_W-1:0].
- One sub-module: rr_arbiter (NUM_SRC-wide request vector plus pointer gives one-hot grant and encoded index, with pointer register and update inside).
- Scoreboard and write-port registers stay in reg_wb_sched.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then all inputs 0 for 5 cycles.
  - Required: write_en=0, busy=0, src_ready=0 throughout, and issue_ready=1 for issue_reg=7.
- Single write:
  - Stimulus: issue reg 5, then src_valid[1]=1, src_reg=5, data=64'hDEAD_BEEF.
  - Required: src_ready=2'b10. Next cycle write_en=1, write_reg=5, write_data=DEAD_BEEF, and busy[5] goes 1 then 0.
- Round-robin contention:
  - Stimulus: both sources valid continuously with regs 3/4, each dropping valid after its accept.
  - Required: grants are src0 then src1, and writes appear to reg 3 then reg 4 on consecutive cycles.
  - Follow-up: if both are re-raised, src0 wins again (pointer wrapped).
- WAW stall and set-wins:
  - Stimulus: busy[9]=1, issue_en with issue_reg=9.
  - Required: issue_ready=0 and busy unchanged.
  - Stimulus: accept a write of reg 9 and, on the next cycle, issue reg 9.
  - Required: issue_ready=1 and busy[9]=1 again.
- x0 handling:
  - Stimulus: issue_en with issue_reg=0, and src_valid[0] with src_reg=0, data=all-ones.
  - Required: issue_ready=1, busy=0, src_ready[0]=1, next-cycle write_en=0, and rr_ptr advances.
- Reset mid-operation:
  - Stimulus: busy[12]=1, with an accept of reg 12 on the edge where rst=1.
  - Required: next cycle write_en=0, busy=0, and the grant returns to src0 on the following contention.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the architectural register address type.
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int XLEN = 64;
  localparam int RA_W = 5;
  typedef logic [RA_W-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_wb_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer,
// with the pointer moving just past each granted requester.
module rr_arbiter #(
  parameter int N = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);
  logic [IDX_W-1:0] ptr_r;
  logic [N-1:0]     grant_s;
  logic [IDX_W-1:0] idx_s;
  logic [IDX_W-1:0] cand_s;
  logic [IDX_W:0]   sum_s;
  logic             found_s;

  // Pick the first request at or above the pointer, wrapping modulo N.
  always_comb begin
    grant_s = '0;
    idx_s   = '0;
    cand_s  = '0;
    sum_s   = '0;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr_r} + (IDX_W+1)'(k);
      if (sum_s >= (IDX_W+1)'(N)) begin
        sum_s = sum_s - (IDX_W+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IDX_W-1:0];
      if (req[cand_s] && !found_s && !rst) begin
        grant_s[cand_s] = 1'b1;
        idx_s           = cand_s;
        found_s         = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer register: next search starts after the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= (idx_s == IDX_W'(N-1)) ? '0 : idx_s + IDX_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant     = grant_s;
  assign grant_idx = idx_s;
endmodule

// File: rtl/reg_wb_sched.sv
// Writeback scheduler: round-robin onto the single register-file write port,
// with a per-register busy scoreboard for RAW/WAW stalls and x0 suppression.
module reg_wb_sched
  import regfile_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int XLEN    = 64,
  parameter int RA_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*RA_W-1:0] src_reg,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic                    issue_en,
  input  logic [RA_W-1:0]         issue_reg,
  output logic                    issue_ready,
  output logic                    write_en,
  output logic [RA_W-1:0]         write_reg,
  output logic [XLEN-1:0]         write_data,
  output logic [NUM_REGS-1:0]     busy
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]  grant_s;
  logic [IDX_W-1:0]    gidx_s;
  logic                acc_s;
  logic [RA_W-1:0]     acc_reg_s;
  logic [XLEN-1:0]     acc_data_s;
  logic                issue_ready_s;
  logic                set_s;
  logic                clr_s;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [NUM_REGS-1:0] busy_r;
  logic                write_en_r;
  logic [RA_W-1:0]     write_reg_r;
  logic [XLEN-1:0]     write_data_r;

  rr_arbiter #(.N(NUM_SRC), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (src_valid),
    .grant     (grant_s),
    .grant_idx (gidx_s)
  );

  // Winner selection, reservation check and next scoreboard value.
  always_comb begin
    acc_s         = |grant_s;
    acc_reg_s     = src_reg[gidx_s*RA_W +: RA_W];
    acc_data_s    = src_data[gidx_s*XLEN +: XLEN];
    issue_ready_s = (issue_reg == REG_ZERO) | ~busy_r[issue_reg];
    set_s         = issue_en & issue_ready_s & (issue_reg != REG_ZERO);
    clr_s         = acc_s & (acc_reg_s != REG_ZERO);
    busy_nxt_s    = busy_r;
    if (clr_s) begin
      busy_nxt_s[acc_reg_s] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    // Applied after the clear so a same-edge reservation wins.
    if (set_s) begin
      busy_nxt_s[issue_reg] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Write-port and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r       <= '0;
      write_en_r   <= 1'b0;
      write_reg_r  <= '0;
      write_data_r <= '0;
    end else begin
      busy_r     <= busy_nxt_s;
      write_en_r <= clr_s;
      if (acc_s) begin
        write_reg_r  <= acc_reg_s;
        write_data_r <= acc_data_s;
      end else begin
        write_reg_r  <= write_reg_r;
        write_data_r <= write_data_r;
      end
    end
  end

  assign src_ready   = grant_s;
  assign issue_ready = issue_ready_s;
  assign write_en    = write_en_r;
  assign write_reg   = write_reg_r;
  assign write_data  = write_data_r;
  assign busy        = busy_r;
endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed vector table plus randomized traffic against a behavioural model
// of the writeback scheduler and scoreboard.
module tb_reg_wb_sched;
  localparam int NS = 2;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS-1:0]  src_valid;
  logic [NS*5-1:0] src_reg;
  logic [NS*64-1:0] src_data;
  logic [NS-1:0]  src_ready;
  logic           issue_en;
  logic [4:0]     issue_reg;
  logic           issue_ready;
  logic           write_en;
  logic [4:0]     write_reg;
  logic [63:0]    write_data;
  logic [31:0]    busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit [31:0]   m_busy;
  int          m_ptr;
  bit          m_we;
  logic [4:0]  m_wreg;
  logic [63:0] m_wd;
  logic [4:0]  r_a [NS];
  logic [63:0] d_a [NS];

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [4:0]  r0;
    logic [63:0] d0;
    logic [4:0]  r1;
    logic [63:0] d1;
    logic        ien;
    logic [4:0]  ireg;
    logic [1:0]  e_ready;
    logic        e_ir;
    logic        e_we;
    logic [4:0]  e_wreg;
    logic [63:0] e_wd;
    logic [31:0] e_busy;
    logic        chk_w;
  } vec_t;

  vec_t tab [$];
  vec_t none;

  reg_wb_sched #(.NUM_SRC(NS), .XLEN(64), .RA_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_reg     (src_reg),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .issue_en    (issue_en),
    .issue_reg   (issue_reg),
    .issue_ready (issue_ready),
    .write_en    (write_en),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rs, logic [1:0] v, logic [4:0] r0, logic [63:0] d0,
                              logic [4:0] r1, logic [63:0] d1, logic ien, logic [4:0] ireg,
                              logic [1:0] er, logic eir, logic ewe, logic [4:0] ewr,
                              logic [63:0] ewd, logic [31:0] eb, logic cw);
    vec_t t;
    t.rst = rs; t.valid = v; t.r0 = r0; t.d0 = d0; t.r1 = r1; t.d1 = d1;
    t.ien = ien; t.ireg = ireg; t.e_ready = er; t.e_ir = eir; t.e_we = ewe;
    t.e_wreg = ewr; t.e_wd = ewd; t.e_busy = eb; t.chk_w = cw;
    return t;
  endfunction

  // First valid requester scanning upward from the pointer, or -1.
  function automatic int pick(logic [NS-1:0] v, int p);
    for (int k = 0; k < NS; k++) begin
      if (v[(p + k) % NS]) return (p + k) % NS;
    end
    return -1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      src_reg[i*5 +: 5]   = r_a[i];
      src_data[i*64 +: 64] = d_a[i];
    end
  endtask

  task automatic model_edge(input int g);
    bit set;
    set = issue_en && !m_busy[issue_reg] && (issue_reg != 5'd0);
    if (rst) begin
      m_busy = '0; m_ptr = 0; m_we = 1'b0; m_wreg = '0; m_wd = '0;
    end else begin
      m_we = 1'b0;
      if (g >= 0) begin
        m_ptr  = (g + 1) % NS;
        m_wreg = src_reg[g*5 +: 5];
        m_wd   = src_data[g*64 +: 64];
        if (m_wreg != 5'd0) begin
          m_we = 1'b1;
          m_busy[m_wreg] = 1'b0;
        end
      end
      if (set) m_busy[issue_reg] = 1'b1;
    end
  endtask

  task automatic run_cycle(input bit use_tab, input vec_t t, output int g);
    logic [NS-1:0] er;
    logic eir;
    #1;
    g   = rst ? -1 : pick(src_valid, m_ptr);
    er  = (g < 0) ? '0 : (NS'(1) << g);
    eir = (issue_reg == 5'd0) || !m_busy[issue_reg];
    if (use_tab) begin
      er  = t.e_ready;
      eir = t.e_ir;
    end
    chk("src_ready", src_ready, er);
    chk("issue_ready", issue_ready, eir);
    @(posedge clk);
    model_edge(g);
    #1;
    if (use_tab) begin
      chk("write_en", write_en, t.e_we);
      chk("busy", busy, t.e_busy);
      if (t.chk_w) begin
        chk("write_reg", write_reg, t.e_wreg);
        chk("write_data", write_data, t.e_wd);
      end
    end else begin
      chk("write_en", write_en, m_we);
      chk("busy", busy, m_busy);
      if (m_we) begin
        chk("write_reg", write_reg, m_wreg);
        chk("write_data", write_data, m_wd);
      end
    end
    cyc++;
  endtask

  initial begin
    int g;
    rst = 1'b1; src_valid = '0; issue_en = 1'b0; issue_reg = '0;
    for (int i = 0; i < NS; i++) begin r_a[i] = '0; d_a[i] = '0; end
    drive();
    m_busy = '0; m_ptr = 0; m_we = 1'b0; m_wreg = '0; m_wd = '0;

    // reset, idle
    tab.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1));
    tab.push_back(mk(1, 2'b00, 0, 0, 0, 0, 0, 7, 2'b00, 1, 0, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++)
      tab.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 7, 2'b00, 1, 0, 0, 0, 0, 1));
    // single write to reg 5
    tab.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 5, 2'b00, 1, 0, 0, 0, 32'h20, 1));
    tab.push_back(mk(0, 2'b10, 0, 0, 5, 64'hDEAD_BEEF, 0, 5, 2'b10, 0, 1, 5, 64'hDEAD_BEEF, 0, 1));
    tab.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 5, 2'b00, 1, 0, 5, 64'hDEAD_BEEF, 0, 1));
    // round-robin contention on regs 3/4
    tab.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 3, 2'b00, 1, 0, 5, 64'hDEAD_BEEF, 32'h8, 1));
    tab.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 4, 2'b00, 1, 0, 5, 64'hDEAD_BEEF, 32'h18, 1));
    tab.push_back(mk(0, 2'b11, 3, 64'h33, 4, 64'h44, 0, 0, 2'b01, 1, 1, 3, 64'h33, 32'h10, 1));
    tab.push_back(mk(0, 2'b10, 3, 64'h33, 4, 64'h44, 0, 0, 2'b10, 1, 1, 4, 64'h44, 0, 1));
    tab.push_back(mk(0, 2'b11, 3, 64'h55, 4, 64'h66, 0, 0, 2'b01, 1, 1, 3, 64'h55, 0, 1));
    tab.push_back(mk(0, 2'b10, 3, 64'h55, 4, 64'h66, 0, 0, 2'b10, 1, 1, 4, 64'h66, 0, 1));
    tab.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 4, 64'h66, 0, 1));
    // WAW stall on reg 9, then set-wins on the same edge
    tab.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 2'b00, 1, 0, 4, 64'h66, 32'h200, 1));
    tab.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 2'b00, 0, 0, 4, 64'h66, 32'h200, 1));
    tab.push_back(mk(0, 2'b01, 9, 64'h99, 0, 0, 1, 9, 2'b01, 0, 1, 9, 64'h99, 0, 1));
    tab.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 2'b00, 1, 0, 9, 64'h99, 32'h200, 1));
    tab.push_back(mk(0, 2'b10, 0, 0, 9, 64'hA9, 0, 9, 2'b10, 0, 1, 9, 64'hA9, 0, 1));
    tab.push_back(mk(0, 2'b01, 9, 64'hB9, 0, 0, 1, 9, 2'b01, 1, 1, 9, 64'hB9, 32'h200, 1));
    // x0: consumed, no write, pointer advances
    tab.push_back(mk(0, 2'b10, 0, 0, 9, 64'hC9, 0, 0, 2'b10, 1, 1, 9, 64'hC9, 0, 1));
    tab.push_back(mk(0, 2'b01, 0, ONES, 0, 0, 1, 0, 2'b01, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 2'b11, 1, 64'h1, 2, 64'h2, 0, 0, 2'b10, 1, 1, 2, 64'h2, 0, 1));
    tab.push_back(mk(0, 2'b01, 1, 64'h1, 0, 0, 0, 0, 2'b01, 1, 1, 1, 64'h1, 0, 1));
    // reset mid-operation with reg 12 busy and a pending write
    tab.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 12, 2'b00, 1, 0, 1, 64'h1, 32'h1000, 1));
    tab.push_back(mk(1, 2'b10, 0, 0, 12, 64'hCC, 0, 12, 2'b00, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 2'b11, 13, 64'hD, 12, 64'hC, 0, 0, 2'b01, 1, 1, 13, 64'hD, 0, 1));
    tab.push_back(mk(0, 2'b10, 13, 64'hD, 12, 64'hC, 0, 0, 2'b10, 1, 1, 12, 64'hC, 0, 1));
    tab.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 12, 64'hC, 0, 1));

    foreach (tab[i]) begin
      rst = tab[i].rst; src_valid = tab[i].valid;
      r_a[0] = tab[i].r0; d_a[0] = tab[i].d0; r_a[1] = tab[i].r1; d_a[1] = tab[i].d1;
      issue_en = tab[i].ien; issue_reg = tab[i].ireg;
      drive();
      run_cycle(1'b1, tab[i], g);
    end

    // randomized traffic; requesters hold until granted
    src_valid = '0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NS; i++) begin
        if (!src_valid[i] && ($urandom_range(0, 1) == 1)) begin
          src_valid[i] = 1'b1;
          r_a[i] = 5'($urandom_range(0, 15));
          d_a[i] = {$urandom(), $urandom()};
        end
      end
      issue_en  = ($urandom_range(0, 1) == 1);
      issue_reg = 5'($urandom_range(0, 15));
      drive();
      run_cycle(1'b0, none, g);
      if (g >= 0) src_valid[g] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
